// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: op field layout, size codes, FSM states, IO decode.
package mem_ctrl_pkg;

  localparam int unsigned OP_STORE_BIT    = 3;
  localparam int unsigned OP_UNSIGNED_BIT = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Addresses whose bits [17:16] are both set fall in IO space.
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
  localparam logic [31:0] IO_DECODE_MASK  = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Number of bus bytes for an op size code; the unused code is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load by op[2:0].
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  op_i,
  output logic [31:0] ext_o
);

  // Pick the extension source bit from the size code; op[2] forces zero fill.
  always_comb begin
    ext_o = raw_i;
    case (op_i[1:0])
      SZ_BYTE: ext_o = op_i[OP_UNSIGNED_BIT] ? {24'h0, raw_i[7:0]}
                                             : {{24{raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: ext_o = op_i[OP_UNSIGNED_BIT] ? {16'h0, raw_i[15:0]}
                                             : {{16{raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller serving LSB loads/stores and instruction fetches.
// Optional: define MEMCTRL_IO_STALL_EN to stall IO-space writes while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IO_BASE_DEFAULT)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_flag,
  input  logic                  full_mem,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data,
  input  logic                  load_or_store,
  input  logic [3:0]            op,
  output logic                  mem_ready,
  output logic [31:0]           mem_val,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [2:0]              op_q;
  logic                    fetch_q;
  logic [2:0]              n_q;
  logic [2:0]              cnt_q;     // READ: edges since accept; WRITE: bytes written
  logic [31:0]             wdata_q;
  logic [31:0]             buf_q;

  logic [1:0]              rx_idx;
  logic [31:0]             asm_d;
  logic [31:0]             ext_val;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    io_hit;
  logic                    wr_stall;
  logic                    unused_sig;

  // Merge the byte arriving this cycle into the partially assembled word.
  always_comb begin
    rx_idx  = 2'(cnt_q - 3'd2);
    asm_d   = buf_q;
    asm_d[{rx_idx, 3'b000} +: 8] = mem_din;
    wr_addr = (state_q == ST_IDLE) ? addr : base_q + ADDR_WIDTH'(cnt_q);
    io_hit  = (wr_addr & ADDR_WIDTH'(IO_DECODE_MASK)) == IO_BASE;
  end

`ifdef MEMCTRL_IO_STALL_EN
  assign wr_stall   = io_buffer_full & io_hit;
  assign unused_sig = load_or_store;
`else
  assign wr_stall   = 1'b0;
  assign unused_sig = ^{load_or_store, io_buffer_full, io_hit};
`endif

  load_extend u_load_extend (
    .raw_i (asm_d),
    .op_i  (op_q),
    .ext_o (ext_val)
  );

  // Request FSM; every bus and completion output is registered here.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      op_q      <= '0;
      fetch_q   <= 1'b0;
      n_q       <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      mem_ready <= 1'b0;
      mem_val   <= '0;
      if_ready  <= 1'b0;
      if_data   <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
    end else if (rdy_in) begin
      mem_ready <= 1'b0;
      if_ready  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (full_mem) begin
            base_q  <= addr;
            op_q    <= op[2:0];
            fetch_q <= 1'b0;
            n_q     <= size_bytes(op[1:0]);
            wdata_q <= data;
            buf_q   <= '0;
            mem_a   <= addr;
            if (op[OP_STORE_BIT]) begin
              state_q <= ST_WRITE;
              if (wr_stall) begin
                mem_wr <= 1'b0;
                cnt_q  <= 3'd0;
              end else begin
                mem_wr   <= 1'b1;
                mem_dout <= data[7:0];
                cnt_q    <= 3'd1;
              end
            end else begin
              state_q <= ST_READ;
              mem_wr  <= 1'b0;
              cnt_q   <= 3'd1;
            end
          end else if (if_valid && !clear_flag) begin
            base_q  <= if_addr;
            op_q    <= {1'b0, SZ_WORD};
            fetch_q <= 1'b1;
            n_q     <= 3'd4;
            buf_q   <= '0;
            mem_a   <= if_addr;
            mem_wr  <= 1'b0;
            cnt_q   <= 3'd1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (fetch_q && clear_flag) begin
            state_q <= ST_IDLE;
            mem_a   <= '0;
            mem_wr  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            // Address of byte cnt goes out now; byte cnt-2 is on mem_din.
            cnt_q <= cnt_q + 3'd1;
            mem_a <= (cnt_q < n_q) ? base_q + ADDR_WIDTH'(cnt_q) : '0;
            if (cnt_q >= 3'd2) buf_q <= asm_d;
            if (cnt_q == n_q + 3'd1) begin
              if (fetch_q) begin
                if_ready <= 1'b1;
                if_data  <= asm_d;
              end else begin
                mem_ready <= 1'b1;
                mem_val   <= ext_val;
              end
              state_q <= ST_DONE;
              cnt_q   <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (cnt_q == n_q) begin
            mem_wr    <= 1'b0;
            mem_a     <= '0;
            mem_ready <= 1'b1;
            mem_val   <= '0;
            state_q   <= ST_DONE;
            cnt_q     <= '0;
          end else if (wr_stall) begin
            mem_wr <= 1'b0;
            mem_a  <= wr_addr;
          end else begin
            mem_wr   <= 1'b1;
            mem_a    <= wr_addr;
            mem_dout <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_q    <= cnt_q + 3'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl with a byte-wide RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_flag, full_mem, load_or_store;
  logic [31:0] addr, data, if_addr;
  logic [3:0]  op;
  logic        mem_ready, if_ready, if_valid, mem_wr, io_buffer_full;
  logic [31:0] mem_val, if_data, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:1023];
  int          wr_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ram_word;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [10];

  mem_ctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .full_mem(full_mem), .addr(addr), .data(data), .load_or_store(load_or_store),
    .op(op), .mem_ready(mem_ready), .mem_val(mem_val), .if_valid(if_valid),
    .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Read data follows its address by one cycle; writes are only counted.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) ram[10'(a + 32'(k))] = w[8*k +: 8];
  endtask

  // One LSB transaction with a per-cycle bus trace check; full_mem is held across DONE.
  task automatic run_lsb(input logic [3:0] op_v, input logic [31:0] a, input logic [31:0] d,
                         input logic clr, output int lat, output logic [31:0] val,
                         output logic trace_ok);
    int n;
    logic [31:0] exp_a;
    logic exp_wr;
    n = nbytes(op_v[1:0]);
    trace_ok = 1'b1; lat = 0; val = 32'hxxxx_xxxx;
    op = op_v; addr = a; data = d; load_or_store = op_v[3];
    full_mem = 1'b1; clear_flag = clr;
    tick();
    if (mem_a !== a || mem_wr !== op_v[3]) trace_ok = 1'b0;
    if (op_v[3] && mem_dout !== d[7:0]) trace_ok = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (mem_ready === 1'b1) begin
        lat = j; val = mem_val;
        if (mem_wr !== 1'b0) trace_ok = 1'b0;
        break;
      end
      exp_a  = (j < n) ? a + 32'(j) : 32'h0;
      exp_wr = op_v[3] && (j < n);
      if (mem_a !== exp_a || mem_wr !== exp_wr) trace_ok = 1'b0;
      if (exp_wr && mem_dout !== d[8*j +: 8]) trace_ok = 1'b0;
    end
    tick();
    if (mem_ready !== 1'b0 || mem_a !== 32'h0 || mem_wr !== 1'b0) trace_ok = 1'b0;
    full_mem = 1'b0; clear_flag = 1'b0;
    tick();
    if (mem_a !== 32'h0 || mem_ready !== 1'b0) trace_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, n, seen;
    logic [31:0] val;
    logic ok;

    vecs[0] = '{4'b0010, 32'h0000_0100, 32'h0, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{4'b0000, 32'h0000_0200, 32'h0, 32'h0000_0080, 32'hFFFF_FF80};
    vecs[2] = '{4'b0100, 32'h0000_0200, 32'h0, 32'h0000_0080, 32'h0000_0080};
    vecs[3] = '{4'b0001, 32'h0000_0210, 32'h0, 32'h0000_8001, 32'hFFFF_8001};
    vecs[4] = '{4'b0101, 32'h0000_0210, 32'h0, 32'h0000_8001, 32'h0000_8001};
    vecs[5] = '{4'b0000, 32'h0000_0220, 32'h0, 32'h0000_007F, 32'h0000_007F};
    vecs[6] = '{4'b0010, 32'hFFFF_FFFE, 32'h0, 32'hA1B2_C3D4, 32'hA1B2_C3D4};
    vecs[7] = '{4'b1010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 32'h0};
    vecs[8] = '{4'b1000, 32'h0000_0310, 32'h1234_56AB, 32'h0, 32'h0};
    vecs[9] = '{4'b1001, 32'h0000_0320, 32'h0000_BEEF, 32'h0, 32'h0};

    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; full_mem = 1'b0;
    load_or_store = 1'b0; addr = '0; data = '0; op = '0; if_valid = 1'b0;
    if_addr = '0; io_buffer_full = 1'b0;
    repeat (3) tick();
    chk("rst mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst mem_val", mem_val, 32'h0);
    chk("rst if_ready", {31'h0, if_ready}, 32'h0);
    chk("rst if_data", if_data, 32'h0);
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst mem_wr", {31'h0, mem_wr}, 32'h0);
    rst_in = 1'b0;

    // rdy_in low: a presented request must not be accepted
    rdy_in = 1'b0; op = 4'b0010; addr = 32'h100; full_mem = 1'b1;
    repeat (3) tick();
    chk("rdy low mem_a", mem_a, 32'h0);
    chk("rdy low mem_ready", {31'h0, mem_ready}, 32'h0);
    full_mem = 1'b0; rdy_in = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].op[3]) preload(vecs[i].addr, vecs[i].ram_word);
      n = nbytes(vecs[i].op[1:0]);
      w0 = wr_cnt;
      run_lsb(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b0, lat, val, ok);
      chk($sformatf("v%0d value", i), val, vecs[i].exp_val);
      chk($sformatf("v%0d latency", i), 32'(lat), vecs[i].op[3] ? 32'(n) : 32'(n + 1));
      chk($sformatf("v%0d bus trace", i), {31'h0, ok}, 32'h1);
      if (vecs[i].op[3]) chk($sformatf("v%0d write cycles", i), 32'(wr_cnt - w0), 32'(n));
    end

    // Simultaneous LSB and fetch: LSB first, fetch right after the cooldown
    preload(32'h120, 32'h00A0_0093);
    op = 4'b0010; addr = 32'h100; load_or_store = 1'b0; full_mem = 1'b1;
    if_valid = 1'b1; if_addr = 32'h120;
    tick();
    chk("arb lsb addr first", mem_a, 32'h100);
    seen = 0; val = 32'h0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (if_ready === 1'b1) seen++;
      if (mem_ready === 1'b1) begin val = mem_val; break; end
    end
    chk("arb lsb value", val, 32'h1234_5678);
    chk("arb no early fetch", 32'(seen), 32'h0);
    tick();
    full_mem = 1'b0;
    lat = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (if_ready === 1'b1) begin lat = j; val = if_data; break; end
    end
    chk("arb fetch latency", 32'(lat), 32'd6);
    chk("arb if_data", val, 32'h00A0_0093);
    if_valid = 1'b0;
    repeat (2) tick();

    // Fetch aborted by clear_flag during READ
    if_valid = 1'b1; if_addr = 32'h140;
    tick();
    chk("clr fetch accepted", mem_a, 32'h140);
    repeat (2) tick();
    clear_flag = 1'b1; if_valid = 1'b0;
    tick();
    chk("clr fetch mem_a idle", mem_a, 32'h0);
    clear_flag = 1'b0;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (if_ready === 1'b1) seen++;
    end
    chk("clr fetch no if_ready", 32'(seen), 32'h0);
    if_valid = 1'b1; if_addr = 32'h160; clear_flag = 1'b1;
    tick();
    chk("clr new fetch rejected", mem_a, 32'h0);
    if_valid = 1'b0; clear_flag = 1'b0;
    tick();

    // Store with clear_flag still completes every byte
    w0 = wr_cnt;
    run_lsb(4'b1010, 32'h340, 32'hCAFE_F00D, 1'b1, lat, val, ok);
    chk("clr store latency", 32'(lat), 32'd4);
    chk("clr store trace", {31'h0, ok}, 32'h1);
    chk("clr store writes", 32'(wr_cnt - w0), 32'd4);

    // Reset in the middle of a store abandons it
    op = 4'b1010; addr = 32'h380; data = 32'h1122_3344; full_mem = 1'b1;
    repeat (2) tick();
    rst_in = 1'b1; full_mem = 1'b0;
    tick();
    chk("midrst mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("midrst mem_a", mem_a, 32'h0);
    rst_in = 1'b0;
    w0 = wr_cnt;
    repeat (5) tick();
    chk("midrst no writes", 32'(wr_cnt - w0), 32'h0);

    // IO-space byte store with io_buffer_full high
    io_buffer_full = 1'b1; op = 4'b1000; addr = 32'h0003_0000; data = 32'h0000_005A;
    full_mem = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
    seen = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (mem_wr === 1'b1) seen++;
    end
    chk("io stall no write", 32'(seen), 32'h0);
    io_buffer_full = 1'b0;
    tick();
    chk("io released mem_wr", {31'h0, mem_wr}, 32'h1);
    chk("io released dout", {24'h0, mem_dout}, 32'h5A);
    tick();
    chk("io mem_ready", {31'h0, mem_ready}, 32'h1);
`else
    tick();
    chk("io ignored mem_wr", {31'h0, mem_wr}, 32'h1);
    chk("io ignored dout", {24'h0, mem_dout}, 32'h5A);
    tick();
    chk("io mem_ready", {31'h0, mem_ready}, 32'h1);
`endif
    tick();
    full_mem = 1'b0; io_buffer_full = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
